lut_sweep_checker: RTL and testbench
====================================

// Module: lut_sweep_checker
// PURPOSE
//  On-fabric stimulus/checker for the install-test LUT designs. Sits upstream and
//  downstream of the LUT under test: drives every input vector in order, waits a
//  fixed settle time, samples the LUT output and compares it against an expected
//  truth table. Reports a pass/fail verdict, an error count and the first failing
//  vector, so a bench (or a board) checks the LUT with one start pulse.
// PARAMETERS
//  N_INPUTS       2       LUT input count, 1..6
//  INIT           4'b1010 expected truth table, 2**N_INPUTS bits; bit k = expected O for I==k
//  SETTLE_CYCLES  4       clocks between driving a vector and sampling, 1..255
// PORTS
//  clk         in   1         single clock, all state updates on rising edge
//  rst_n       in   1         synchronous reset, active-low
//  start       in   1         begin a sweep; sampled only in IDLE or DONE
//  lut_i       out  N_INPUTS  vector driven to LUT under test
//  lut_o       in   1         LUT under test output
//  busy        out  1         high from the cycle after start until DONE is entered
//  done        out  1         high in DONE; held until the next accepted start
//  pass        out  1         valid while done=1; 1 iff err_count==0
//  err_count   out  8         mismatches in the last sweep, saturates at 255
//  err_vector  out  N_INPUTS  first failing vector; 0 if none
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, lut_i=0, busy=0, done=0, pass=0,
//   err_count=0, err_vector=0, internal vector/settle counters=0. Reset overrides
//   every other input, including mid-sweep; no partial result survives.
//  FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
//   IDLE  : start=1 -> DRIVE; clear err_count, err_vector, vec=0, done=0.
//   DRIVE : lut_i<=vec; settle counter<=SETTLE_CYCLES-1; -> SETTLE.
//   SETTLE: counter decrements each clk; at 0 -> SAMPLE.
//   SAMPLE: mismatch if (lut_o !== INIT[vec]); X/Z on lut_o counts as mismatch.
//           On mismatch: err_count+=1 (saturating); if first mismatch, err_vector<=vec.
//           If vec==2**N_INPUTS-1 -> DONE, else vec+=1 -> DRIVE.
//   DONE  : done=1, busy=0, pass=(err_count==0); lut_i holds last vector.
//           start=1 -> DRIVE with the same clearing as IDLE (done drops next cycle).
//  Latency per vector: 1 (DRIVE) + SETTLE_CYCLES + 1 (SAMPLE) clocks.
//   Whole sweep: 2**N_INPUTS*(SETTLE_CYCLES+2) clocks from start to done=1.
//  start while busy=1 is ignored; no queuing.
//  vec width is N_INPUTS+1 internally so the last-vector compare is free of
//   wrap-around; lut_i is vec[N_INPUTS-1:0].
//  Error-flag logic: the "first mismatch" flag is err_count==0, not a separate
//   bit; saturation at 255 does not disturb err_vector.
//  lut_o is treated as combinational from lut_i; SETTLE_CYCLES must cover the
//   LUT plus routing delay (timing sim uses SDF-annotated delays).
// TESTING
//  1 ideal LUT (O=I[0]), INIT=4'b1010, SETTLE=4, pulse start -> done after 24
//    clks, pass=1, err_count=0, err_vector=0; lut_i steps 0,1,2,3.
//  2 LUT stuck-at-0 -> pass=0, err_count=2, err_vector=2'b01.
//  3 inverted LUT (O=~I[0]) -> err_count=4, err_vector=2'b00.
//  4 start re-pulsed at clk 5 and clk 10 of a sweep -> ignored; done still at
//    clk 24, single sweep results.
//  5 rst_n=0 for one clk mid-SETTLE of vector 2 -> next cycle all outputs 0,
//    state IDLE; new start gives a full clean sweep.
//  6 lut_o=1'bx for vector 3 only, else ideal -> err_count=1, err_vector=2'b11;
//    second start from DONE clears and re-runs -> identical results.

Source files
------------

// File: rtl/lut_sweep_checker.sv
// lut_sweep_checker
//   Drives every input vector of a LUT under test in ascending order, waits a
//   fixed settle time, samples the LUT output and compares it with the
//   expected truth table INIT. One start pulse yields pass, an error count and
//   the first failing vector.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active low
//   start       begin a sweep (accepted only in IDLE or DONE)
//   lut_i       vector driven to the LUT under test
//   lut_o       output of the LUT under test
//   busy        sweep in progress
//   done        sweep finished, held until the next accepted start
//   pass        valid with done; 1 when no mismatch was seen
//   err_count   mismatches in the last sweep, saturating at 255
//   err_vector  first failing vector, 0 when none
module lut_sweep_checker #(
    parameter int                        N_INPUTS      = 2,
    parameter logic [2**N_INPUTS-1:0]    INIT          = 4'b1010,
    parameter int                        SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [N_INPUTS-1:0] lut_i,
    input  logic                lut_o,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [7:0]          err_count,
    output logic [N_INPUTS-1:0] err_vector
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // One extra bit on vec keeps the last-vector compare free of wrap-around.
    localparam logic [N_INPUTS:0] LAST_VEC    = (N_INPUTS+1)'(2**N_INPUTS - 1);
    localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [2:0]          state;
    logic [N_INPUTS:0]   vec;
    logic [7:0]          settle_cnt;
    logic                mismatch;

    // Case inequality so an unknown LUT output is reported as a mismatch.
    always_comb begin
        mismatch = (lut_o !== INIT[vec[N_INPUTS-1:0]]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            lut_i      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            err_vector <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_DRIVE;
                        vec        <= '0;
                        err_count  <= '0;
                        err_vector <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    lut_i      <= vec[N_INPUTS-1:0];
                    settle_cnt <= SETTLE_LOAD;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == 8'd0) state <= S_SAMPLE;
                    else                    settle_cnt <= settle_cnt - 8'd1;
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        // err_count==0 doubles as the "first mismatch" flag.
                        if (err_count == 8'd0) err_vector <= vec[N_INPUTS-1:0];
                    end
                    if (vec == LAST_VEC) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= !mismatch && (err_count == 8'd0);
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_sweep_checker.sv
module tb_lut_sweep_checker;

    localparam logic [3:0] INIT = 4'b1010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] lut_i;
    logic       lut_o;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [1:0] err_vector;

    int total = 0;
    int bad   = 0;

    // LUT-under-test behaviour: 0 ideal, 1 stuck-at-0, 2 inverted,
    // 3 unknown output on vector 3, 4 arbitrary table rtt
    int         mode;
    logic [3:0] rtt;
    logic       xbit;

    lut_sweep_checker #(.N_INPUTS(2), .INIT(INIT), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lut_i(lut_i), .lut_o(lut_o),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .err_vector(err_vector)
    );

    always #5 clk = ~clk;

    always_comb begin
        lut_o = lut_i[0];
        case (mode)
            1: lut_o = 1'b0;
            2: lut_o = ~lut_i[0];
            3: lut_o = (lut_i == 2'd3) ? xbit : lut_i[0];
            4: lut_o = rtt[lut_i];
            default: lut_o = lut_i[0];
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int seen[$];

    // Pulse start and count clocks until done; records the lut_i sequence.
    task automatic sweep(input bit repulse, output int cyc_done);
        int last;
        last     = -1;
        cyc_done = -1;
        seen.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (repulse) start = (c == 5 || c == 10);
            if (!done && int'(lut_i) != last) begin
                last = int'(lut_i);
                seen.push_back(last);
            end
            if (done) begin
                cyc_done = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    // Reference: expected results straight from the truth tables.
    task automatic check_result(input string tag, input logic [3:0] actual_tt,
                                input bit has_x, input int cyc);
        int errs, first;
        errs  = 0;
        first = 0;
        for (int k = 0; k < 4; k++) begin
            if ((has_x && k == 3) || actual_tt[k] != INIT[k]) begin
                if (errs == 0) first = k;
                errs++;
            end
        end
        chk({tag, "_cycles"}, cyc, 24);
        chk({tag, "_pass"}, pass, (errs == 0) ? 1 : 0);
        chk({tag, "_err_count"}, err_count, errs);
        chk({tag, "_err_vector"}, err_vector, first);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_lut_i_hold"}, lut_i, 3);
        chk({tag, "_lut_i_seq"},
            (seen.size() == 4 && seen[0] == 0 && seen[1] == 1 &&
             seen[2] == 2 && seen[3] == 3) ? 1 : 0, 1);
    endtask

    typedef struct {
        int         m;
        logic [3:0] act_tt;   // table the LUT actually implements
        bit         has_x;
        string      name;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int         cyc;
        logic       probe;
        logic [3:0] tt_of_mode[4];

        // A 2-state simulator cannot hold X; fall back to the wrong value.
        probe = 1'bx;
        xbit  = $isunknown(probe) ? 1'bx : ~INIT[3];

        tt_of_mode[0] = 4'b1010;
        tt_of_mode[1] = 4'b0000;
        tt_of_mode[2] = 4'b0101;
        tt_of_mode[3] = 4'b1010;

        tbl[0] = '{0, tt_of_mode[0], 1'b0, "ideal"};
        tbl[1] = '{1, tt_of_mode[1], 1'b0, "stuck0"};
        tbl[2] = '{2, tt_of_mode[2], 1'b0, "inverted"};
        tbl[3] = '{3, tt_of_mode[3], 1'b1, "x_vec3"};
        tbl[4] = '{3, tt_of_mode[3], 1'b1, "x_vec3_rerun"};

        mode  = 0;
        rtt   = 4'd0;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_err_vector", err_vector, 0);
        chk("rst_lut_i", lut_i, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table; consecutive entries start from DONE.
        foreach (tbl[i]) begin
            mode = tbl[i].m;
            sweep(1'b0, cyc);
            check_result(tbl[i].name, tbl[i].act_tt, tbl[i].has_x, cyc);
            repeat (3) @(posedge clk);
            #1;
            chk({tbl[i].name, "_done_held"}, done, 1);
        end

        // start re-pulsed mid-sweep is ignored
        mode = 0;
        sweep(1'b1, cyc);
        check_result("repulse", 4'b1010, 1'b0, cyc);

        // reset mid-SETTLE of vector 2, then a clean sweep
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_lut_i", lut_i, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pass", pass, 0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_err_vector", err_vector, 0);
        chk("midrst_lut_i", lut_i, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_idle_busy", busy, 0);
        chk("midrst_idle_lut_i", lut_i, 0);
        mode = 0;
        sweep(1'b0, cyc);
        check_result("after_rst", 4'b1010, 1'b0, cyc);

        // random LUT behaviours against the truth-table model
        mode = 4;
        for (int r = 0; r < 10; r++) begin
            rtt = 4'($urandom_range(0, 15));
            sweep(1'b0, cyc);
            check_result($sformatf("rand%0d", r), rtt, 1'b0, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
